puf_challenge_sequencer: RTL and testbench
==========================================

Name: puf_challenge_sequencer

Overview:
Controller that sequences ring-oscillator PUF measurements. On each start it generates NBITS response bits. For each bit it applies a mux select derived from the challenge, gates the oscillator enable for a fixed window, and counts synchronized rising edges of the two oscillator banks (A, B). It then compares the counts and shifts the result into a response register. It sits between the host-facing ui_in/uo_out pins and the two oscillator bank/mux instances, and replaces free-running counting with a timed, repeatable measurement.

Parameters:
SEL_W, 3, width of oscillator mux select
CNT_W, 8, edge counter width; counters saturate at all-ones
SETTLE, 4, clk cycles with oscillators disabled before each window (min 2)
WINDOW, 64, clk cycles of oscillator enable per measurement (min 1)
NBITS, 8, response bits produced per start

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-high
start  input  1  level; sampled only in IDLE
challenge  input  SEL_W  base select; latched on accepted start
ro_a  input  1  bank A muxed oscillator output (asynchronous)
ro_b  input  1  bank B muxed oscillator output (asynchronous)
ro_en  output  1  oscillator enable to both banks
sel  output  SEL_W  mux select to both banks
busy  output  1  high from accepted start until return to IDLE
resp_valid  output  1  one-cycle pulse when response complete
response  output  NBITS  response[i] = bit from measurement i
tie  output  1  sticky: some measurement in this run had cnt_a == cnt_b
cnt_a_last, cnt_b_last  output  CNT_W each  counts from most recent COMPARE

Behaviour:
- Reset (rst_n=1, async): state=IDLE; all outputs 0; counters, bit index, synchronizers and latched challenge cleared. Reset mid-run aborts the run; no resp_valid is issued.
- States: IDLE, SETTLE, MEASURE, COMPARE, DONE.
- IDLE: busy=0, ro_en=0. When start=1, latch challenge into base, clear idx, response, tie and counters; go to SETTLE next cycle. busy=1 from that cycle.
- sel = (base + idx) mod 2^SEL_W. Updated on entry to SETTLE and held through COMPARE. Wraps naturally: base 6 gives 6,7,0,1,...
- SETTLE: ro_en=0 for exactly SETTLE cycles. Counters held at 0; edge detectors keep running so the synchronizer flushes. Then go to MEASURE.
- MEASURE: ro_en=1 for exactly WINDOW cycles. Each input uses a 2-FF synchronizer plus a third FF for edge detect (edge = s2 & ~s3). A cnt increments on each detected rising edge of A, only during MEASURE cycles. B behaves the same with its own counter. Counters saturate at 2^CNT_W-1 and never wrap. Edges still in the synchronizer when the window closes are discarded.
- COMPARE (1 cycle, ro_en=0): bit = (cnt_a > cnt_b), unsigned. If cnt_a == cnt_b, bit=0 and tie sets (sticky until next accepted start). Write response[idx] = bit; capture cnt_a_last/cnt_b_last; clear counters. If idx == NBITS-1, go to DONE; else increment idx and go to SETTLE.
- DONE (1 cycle): resp_valid=1, busy=1. Next cycle go to IDLE.
- response, tie and cnt_*_last hold their values in IDLE until the next accepted start.
- start while busy is ignored. start held high in IDLE retriggers a new run on the cycle after DONE returns to IDLE.
- Total latency from start sample to resp_valid: NBITS*(SETTLE+WINDOW+1)+1 cycles; 553 at defaults.
- ro_a/ro_b toggling while ro_en=0 are never counted.

Test Plan:
- Defaults, challenge=0. ro_a toggles every 2 clk (period 4), ro_b every 4 clk (period 8), both gated by ro_en -> cnt_a_last≈16, cnt_b_last≈8 each bit. Expect response=8'hFF, tie=0, resp_valid exactly 553 cycles after start, one cycle wide.
- challenge=3'd6. Monitor sel across the run -> sequence 6,7,0,1,2,3,4,5. sel is constant within each SETTLE..COMPARE span. busy=1 throughout the run.
- ro_a and ro_b driven by the same waveform -> response=8'h00, tie=1, cnt_a_last==cnt_b_last. A following run with ro_a faster clears tie to 0.
- CNT_W=4, ro_a toggling every clk, ro_b period 8 -> cnt_a_last=15 (saturated, no wrap), cnt_b_last=8, bit=1.
- Pulse start again during MEASURE of bit 2 -> ignored, no restart, single resp_valid. Assert rst_n=1 mid-MEASURE -> all outputs 0 immediately. After release, state is IDLE and no resp_valid occurs until a new start.
- Toggle ro_a/ro_b only while ro_en=0 (SETTLE/IDLE) -> counts 0, response=8'h00, tie=1.

Source files
------------

// File: rtl/puf_challenge_sequencer_if.sv
// Host-side start/challenge handshake and measurement result bundle
// for the ring-oscillator PUF challenge sequencer.
interface puf_challenge_sequencer_if #(
    parameter int SEL_W = 3,
    parameter int CNT_W = 8,
    parameter int NBITS = 8
);
    logic             start;
    logic [SEL_W-1:0] challenge;
    logic             busy;
    logic             resp_valid;
    logic [NBITS-1:0] response;
    logic             tie;
    logic [CNT_W-1:0] cnt_a_last;
    logic [CNT_W-1:0] cnt_b_last;

    modport master (
        output start, challenge,
        input  busy, resp_valid, response, tie, cnt_a_last, cnt_b_last
    );

    modport slave (
        input  start, challenge,
        output busy, resp_valid, response, tie, cnt_a_last, cnt_b_last
    );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// Sequences NBITS timed ring-oscillator race measurements per start and
// shifts each A-vs-B comparison into the response register.
module puf_challenge_sequencer #(
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 8,
    parameter int SETTLE = 4,
    parameter int WINDOW = 64,
    parameter int NBITS  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    puf_challenge_sequencer_if.slave  host,
    input  logic                      ro_a,
    input  logic                      ro_b,
    output logic                      ro_en,
    output logic [SEL_W-1:0]          sel
);
    localparam int IDX_W   = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int TMR_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] base;
    logic [IDX_W-1:0] idx;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic [2:0]       sync_a;
    logic [2:0]       sync_b;
    logic             edge_a;
    logic             edge_b;

    logic             busy_r;
    logic             resp_valid_r;
    logic [NBITS-1:0] response_r;
    logic             tie_r;
    logic [CNT_W-1:0] cnt_a_last_r;
    logic [CNT_W-1:0] cnt_b_last_r;

    // Inputs are masked by the registered enable so that activity while the
    // banks are disabled can never reach the counters, even through the
    // synchronizer latency at the start of a window.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[1:0], ro_a & ro_en};
            sync_b <= {sync_b[1:0], ro_b & ro_en};
        end
    end

    assign edge_a = sync_a[1] & ~sync_a[2];
    assign edge_b = sync_b[1] & ~sync_b[2];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state        <= S_IDLE;
            base         <= '0;
            idx          <= '0;
            tmr          <= '0;
            cnt_a        <= '0;
            cnt_b        <= '0;
            ro_en        <= 1'b0;
            sel          <= '0;
            busy_r       <= 1'b0;
            resp_valid_r <= 1'b0;
            response_r   <= '0;
            tie_r        <= 1'b0;
            cnt_a_last_r <= '0;
            cnt_b_last_r <= '0;
        end else begin
            resp_valid_r <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (host.start) begin
                        base       <= host.challenge;
                        sel        <= host.challenge;
                        idx        <= '0;
                        tmr        <= '0;
                        response_r <= '0;
                        tie_r      <= 1'b0;
                        cnt_a      <= '0;
                        cnt_b      <= '0;
                        busy_r     <= 1'b1;
                        state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (tmr == TMR_W'(SETTLE - 1)) begin
                        tmr   <= '0;
                        ro_en <= 1'b1;
                        state <= S_MEASURE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (edge_a && (cnt_a != '1)) begin
                        cnt_a <= cnt_a + 1'b1;
                    end
                    if (edge_b && (cnt_b != '1)) begin
                        cnt_b <= cnt_b + 1'b1;
                    end
                    if (tmr == TMR_W'(WINDOW - 1)) begin
                        tmr   <= '0;
                        ro_en <= 1'b0;
                        state <= S_COMPARE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_COMPARE: begin
                    response_r[idx] <= (cnt_a > cnt_b);
                    if (cnt_a == cnt_b) begin
                        tie_r <= 1'b1;
                    end
                    cnt_a_last_r <= cnt_a;
                    cnt_b_last_r <= cnt_b;
                    cnt_a        <= '0;
                    cnt_b        <= '0;
                    if (idx == IDX_W'(NBITS - 1)) begin
                        resp_valid_r <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        sel   <= base + SEL_W'(idx) + SEL_W'(1);
                        state <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign host.busy       = busy_r;
    assign host.resp_valid = resp_valid_r;
    assign host.response   = response_r;
    assign host.tie        = tie_r;
    assign host.cnt_a_last = cnt_a_last_r;
    assign host.cnt_b_last = cnt_b_last_r;
endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed-plus-random bench for puf_challenge_sequencer: two instances
// (8-bit and 4-bit counters) checked against a waveform-level edge model.
module tb_puf_challenge_sequencer;
    localparam int S  = 4;
    localparam int W  = 64;
    localparam int NB = 8;
    localparam int B  = S + W + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ro_a;
    logic       ro_b;
    logic       ro_en8;
    logic       ro_en4;
    logic [2:0] sel8;
    logic [2:0] sel4;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int run_id     = 0;
    int T0         = 0;
    int ha_c = 0, pa_c = 0, hb_c = 0, pb_c = 0, mode_c = 0;

    always #5 clk = ~clk;

    puf_challenge_sequencer_if #(.SEL_W(3), .CNT_W(8), .NBITS(NB)) hif8 ();
    puf_challenge_sequencer_if #(.SEL_W(3), .CNT_W(4), .NBITS(NB)) hif4 ();

    puf_challenge_sequencer #(.SEL_W(3), .CNT_W(8), .SETTLE(S), .WINDOW(W), .NBITS(NB)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .host(hif8.slave),
        .ro_a(ro_a), .ro_b(ro_b), .ro_en(ro_en8), .sel(sel8)
    );

    puf_challenge_sequencer #(.SEL_W(3), .CNT_W(4), .SETTLE(S), .WINDOW(W), .NBITS(NB)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .host(hif4.slave),
        .ro_a(ro_a), .ro_b(ro_b), .ro_en(ro_en4), .sel(sel4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s (run %0d): observed %0h expected %0h", tag, run_id, got, exp);
        end
    endtask

    // Enable window of the run starting at T0: high during cycle n (after edge n).
    function automatic bit en_at(int n);
        int r = n - T0;
        if (r < 0 || r >= NB * B) return 1'b0;
        return ((r % B) >= S) && ((r % B) < S + W);
    endfunction

    function automatic bit wave(int h, int ph, int p);
        if (h <= 0) return 1'b0;
        return (((p + ph) / h) % 2) == 1;
    endfunction

    function automatic bit drv(bit is_a, int p);
        bit v = is_a ? wave(ha_c, pa_c, p) : wave(hb_c, pb_c, p);
        if (mode_c == 1) v = v & !en_at(p - 1);
        return v;
    endfunction

    // What the oscillator actually delivers at edge p when enabled.
    function automatic bit gated(bit is_a, int p);
        return drv(is_a, p) & en_at(p - 1);
    endfunction

    // Rising edges seen at sample p are recognised two edges later; only
    // recognitions on the W measure edges count, saturating at maxv.
    function automatic int model_cnt(bit is_a, int i, int maxv);
        int ts = T0 + i * B + S;
        int c  = 0;
        for (int p = ts + 1; p <= ts + W - 2; p++) begin
            if (gated(is_a, p) && !gated(is_a, p - 1) && c < maxv) c++;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        ro_a = drv(1'b1, cyc + 1);
        ro_b = drv(1'b0, cyc + 1);
    endtask

    task automatic set_start(input logic v, input logic [2:0] ch);
        hif8.start = v;  hif4.start = v;
        hif8.challenge = ch;  hif4.challenge = ch;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out8"}, {hif8.busy, hif8.resp_valid, ro_en8, sel8, hif8.response,
                             hif8.tie, hif8.cnt_a_last, hif8.cnt_b_last}, 32'd0);
        chk({tag, "_out4"}, {hif4.busy, hif4.resp_valid, ro_en4, sel4, hif4.response,
                             hif4.tie, hif4.cnt_a_last, hif4.cnt_b_last}, 32'd0);
    endtask

    task automatic run(input logic [2:0] ch, input int a_h, a_p, b_h, b_p, md,
                       input bit pulse_mid, input bit hold, input bit abort);
        int D, first_rv, terr, first_bad, r, stray;
        int ea8[NB], eb8[NB], ea4[NB], eb4[NB];
        logic [NB-1:0] resp8, resp4;
        bit tie8, tie4, e_en, e_rv;
        logic [2:0] e_sel;
        run_id++;
        ha_c = a_h; pa_c = a_p; hb_c = b_h; pb_c = b_p; mode_c = md;
        T0 = cyc + 1;
        D  = T0 + NB * B;
        tie8 = 1'b0; tie4 = 1'b0;
        for (int i = 0; i < NB; i++) begin
            ea8[i] = model_cnt(1'b1, i, 255);  eb8[i] = model_cnt(1'b0, i, 255);
            ea4[i] = model_cnt(1'b1, i, 15);   eb4[i] = model_cnt(1'b0, i, 15);
            resp8[i] = ea8[i] > eb8[i];        resp4[i] = ea4[i] > eb4[i];
            if (ea8[i] == eb8[i]) tie8 = 1'b1;
            if (ea4[i] == eb4[i]) tie4 = 1'b1;
        end
        ro_a = drv(1'b1, cyc + 1);
        ro_b = drv(1'b0, cyc + 1);
        set_start(1'b1, ch);
        first_rv = -1; terr = 0; first_bad = -1;
        while (cyc < D) begin
            tick();
            r     = cyc - T0;
            e_en  = en_at(cyc);
            e_rv  = (r == NB * B);
            e_sel = 3'((int'(ch) + r / B) % 8);
            if (hif8.busy !== 1'b1 || hif4.busy !== 1'b1 ||
                hif8.resp_valid !== e_rv || hif4.resp_valid !== e_rv ||
                ro_en8 !== e_en || ro_en4 !== e_en ||
                (r < NB * B && (sel8 !== e_sel || sel4 !== e_sel))) begin
                terr++;
                if (first_bad < 0) first_bad = r;
            end
            if (hif8.resp_valid === 1'b1 && first_rv < 0) first_rv = cyc;
            if (!hold && r == 0) set_start(1'b0, ch);
            if (pulse_mid && r == 2 * B + S + 10) set_start(1'b1, ch);
            if (pulse_mid && r == 2 * B + S + 11) set_start(1'b0, ch);
            if (abort && r == B + S + 5) begin
                chk("abort_trace", terr, 0);
                rst_n = 1'b1;
                #1;
                chk_all_zero("abort_now");
                tick(); tick();
                rst_n = 1'b0;
                stray = 0;
                for (int k = 0; k < 600; k++) begin
                    tick();
                    if (hif8.resp_valid !== 1'b0 || hif8.busy !== 1'b0 ||
                        hif4.resp_valid !== 1'b0 || hif4.busy !== 1'b0) stray++;
                end
                chk("no_rv_after_reset", stray, 0);
                return;
            end
        end
        chk("trace", terr, 0);
        if (terr != 0) $display("  first trace deviation at cycle offset %0d", first_bad);
        chk("latency", first_rv - (T0 - 1), NB * B + 1);
        chk("resp8", hif8.response, resp8);
        chk("resp4", hif4.response, resp4);
        chk("tie8", hif8.tie, tie8);
        chk("tie4", hif4.tie, tie4);
        chk("cnt_a_last8", hif8.cnt_a_last, ea8[NB-1]);
        chk("cnt_b_last8", hif8.cnt_b_last, eb8[NB-1]);
        chk("cnt_a_last4", hif4.cnt_a_last, ea4[NB-1]);
        chk("cnt_b_last4", hif4.cnt_b_last, eb4[NB-1]);
        tick();
        chk("rv_one_cycle", {hif8.resp_valid, hif4.resp_valid, hif8.busy}, 3'b000);
        if (hold) begin
            tick();
            chk("retrigger_busy", {hif8.busy, hif4.busy}, 2'b11);
            set_start(1'b0, ch);
            rst_n = 1'b1;
            tick();
            rst_n = 1'b0;
            tick();
        end else begin
            tick(); tick();
            chk("resp_hold", hif8.response, resp8);
            chk("tie_hold", hif8.tie, tie8);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        ro_a  = 1'b0;
        ro_b  = 1'b0;
        set_start(1'b0, 3'd0);
        tick(); tick(); tick();
        chk_all_zero("reset");
        rst_n = 1'b0;
        tick(); tick();

        // A twice as fast as B from challenge 0.
        run(3'd0, 2, 0, 4, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("basic_resp_ff", hif8.response, 8'hFF);
        // Select wrap from base 6 with random oscillators.
        run(3'd6, int'($urandom_range(1, 8)), int'($urandom_range(0, 7)),
                  int'($urandom_range(1, 8)), int'($urandom_range(0, 7)), 0, 1'b0, 1'b0, 1'b0);
        // Identical waveforms: every bit ties.
        begin
            int h = int'($urandom_range(1, 6));
            int p = int'($urandom_range(0, 7));
            run(3'd2, h, p, h, p, 0, 1'b0, 1'b0, 1'b0);
            chk("same_wave_resp", hif8.response, 8'h00);
            chk("same_wave_tie", hif8.tie, 1'b1);
        end
        // Faster A clears the sticky tie.
        run(3'd5, 1, 0, 3, 1, 0, 1'b0, 1'b0, 1'b0);
        chk("tie_cleared", hif8.tie, 1'b0);
        // A every clk, B period 8: 4-bit counter saturates.
        run(3'd1, 1, 0, 4, 2, 0, 1'b0, 1'b0, 1'b0);
        chk("sat_cnt_a4", hif4.cnt_a_last, 4'd15);
        // Start pulse during bit 2 measurement is ignored.
        run(3'd3, 2, 1, 3, 0, 0, 1'b1, 1'b0, 1'b0);
        // Activity only while disabled is never counted.
        run(3'd4, 1, 0, 2, 1, 1, 1'b0, 1'b0, 1'b0);
        chk("disabled_only_tie", hif8.tie, 1'b1);
        // Start held high retriggers right after DONE.
        run(3'd7, 3, 0, 2, 0, 0, 1'b0, 1'b1, 1'b0);
        // Mid-measurement reset aborts without resp_valid.
        run(3'd0, 2, 0, 4, 0, 0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 3; n++) begin
            run(3'($urandom_range(0, 7)),
                int'($urandom_range(1, 9)), int'($urandom_range(0, 9)),
                int'($urandom_range(1, 9)), int'($urandom_range(0, 9)), 0, 1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
